// File: rtl/pea33_ofm_collector.sv
// rtl/pea33_ofm_collector.sv - per-column sum FIFOs drained round-robin onto one OFM write stream
//
// Purpose:
//   Collects the per-column sum strobes of the 3x3 conv PE array into one FIFO
//   per column. The FIFOs are drained round-robin through a single output
//   register onto a valid/ready stream. Each output word is tagged with its
//   source column and its position in that column's tile line.
//
// Optional feature:
//   PEA33_OFM_RELU_EN - when defined, negative sums are clamped to 0 as they
//   are pushed. When undefined, sums pass through with their sign preserved.
//
// Ports:
//   clk        in   clock
//   rstn       in   asynchronous active-low reset
//   start      in   synchronous clear of all state (conv start pulse)
//   sum_valid  in   [COL]              per-column push strobe
//   sum        in   [COL*OFM_WIDTH]    packed signed sums, column c at [c*OFM_WIDTH +: OFM_WIDTH]
//   out_valid  out  output word valid
//   out_ready  in   downstream accept
//   out_data   out  [OFM_WIDTH]        sum value
//   out_col    out  [$clog2(COL)]      source column
//   out_idx    out  [$clog2(TILE_LEN)] position within the column's tile line
//   out_last   out  high when out_idx == TILE_LEN-1
//   ovf        out  [COL]              sticky per-column overflow
//   idle       out  all FIFOs empty and no word in the output register

module pea33_ofm_collector #(
    parameter int COL        = 8,
    parameter int OFM_WIDTH  = 25,
    parameter int TILE_LEN   = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start,
    input  logic [COL-1:0]                sum_valid,
    input  logic [COL*OFM_WIDTH-1:0]      sum,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OFM_WIDTH-1:0]          out_data,
    output logic [$clog2(COL)-1:0]        out_col,
    output logic [$clog2(TILE_LEN)-1:0]   out_idx,
    output logic                          out_last,
    output logic [COL-1:0]                ovf,
    output logic                          idle
);

    localparam int CW = $clog2(COL);
    localparam int IW = $clog2(TILE_LEN);
    localparam int AW = $clog2(FIFO_DEPTH);

    // FIFO storage and pointers; the extra MSB on each pointer tells full from empty
    logic [OFM_WIDTH-1:0] mem_q [COL][FIFO_DEPTH];
    logic [OFM_WIDTH-1:0] mem_d [COL][FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q [COL];
    logic [AW:0]          wr_ptr_d [COL];
    logic [AW:0]          rd_ptr_q [COL];
    logic [AW:0]          rd_ptr_d [COL];

    logic [IW-1:0]        idx_q [COL];
    logic [IW-1:0]        idx_d [COL];
    logic [COL-1:0]       ovf_q, ovf_d;
    logic [CW-1:0]        rr_ptr_q, rr_ptr_d;

    logic                 out_valid_q, out_valid_d;
    logic [OFM_WIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]        out_col_q, out_col_d;
    logic [IW-1:0]        out_idx_q, out_idx_d;
    logic                 out_last_q, out_last_d;

    logic [COL-1:0]       fifo_empty;
    logic [COL-1:0]       fifo_full;
    logic [OFM_WIDTH-1:0] push_data [COL];
    logic                 load_en;
    logic                 grant_any;
    logic [CW-1:0]        grant_col;

    always_comb begin
        for (int c = 0; c < COL; c++) begin
            fifo_empty[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
            fifo_full[c]  = (wr_ptr_q[c][AW] != rd_ptr_q[c][AW]) &&
                            (wr_ptr_q[c][AW-1:0] == rd_ptr_q[c][AW-1:0]);
            push_data[c]  = sum[c*OFM_WIDTH +: OFM_WIDTH];
`ifdef PEA33_OFM_RELU_EN
            if (push_data[c][OFM_WIDTH-1]) begin
                push_data[c] = '0;
            end
`endif
        end
    end

    // The output register accepts a new word when empty or when its current word leaves
    assign load_en = !out_valid_q || out_ready;

    // Round-robin: first non-empty FIFO at or after the column following the last grant
    always_comb begin
        int cand;
        grant_any = 1'b0;
        grant_col = '0;
        cand      = 0;
        for (int i = 0; i < COL; i++) begin
            cand = (int'(rr_ptr_q) + i) % COL;
            if (!grant_any && !fifo_empty[cand]) begin
                grant_any = 1'b1;
                grant_col = CW'(cand);
            end
        end
    end

    always_comb begin
        logic pop_c;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        idx_d       = idx_q;
        ovf_d       = ovf_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_col_d   = out_col_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        pop_c       = 1'b0;

        for (int c = 0; c < COL; c++) begin
            pop_c = load_en && grant_any && (grant_col == CW'(c));
            // A full FIFO still takes a push when it is popped in the same cycle
            if (sum_valid[c] && (!fifo_full[c] || pop_c)) begin
                mem_d[c][wr_ptr_q[c][AW-1:0]] = push_data[c];
                wr_ptr_d[c] = wr_ptr_q[c] + (AW+1)'(1);
            end
            if (sum_valid[c] && fifo_full[c] && !pop_c) begin
                ovf_d[c] = 1'b1;
            end
            if (pop_c) begin
                rd_ptr_d[c] = rd_ptr_q[c] + (AW+1)'(1);
            end
        end

        if (load_en) begin
            out_valid_d = grant_any;
            if (grant_any) begin
                out_data_d = mem_q[grant_col][rd_ptr_q[grant_col][AW-1:0]];
                out_col_d  = grant_col;
                out_idx_d  = idx_q[grant_col];
                out_last_d = (idx_q[grant_col] == IW'(TILE_LEN-1));
                idx_d[grant_col] = (idx_q[grant_col] == IW'(TILE_LEN-1)) ?
                                   '0 : idx_q[grant_col] + IW'(1);
                rr_ptr_d = (grant_col == CW'(COL-1)) ? '0 : grant_col + CW'(1);
            end
        end

        // start overrides everything above, including same-cycle pushes
        if (start) begin
            for (int c = 0; c < COL; c++) begin
                wr_ptr_d[c] = '0;
                rd_ptr_d[c] = '0;
                idx_d[c]    = '0;
            end
            ovf_d       = '0;
            rr_ptr_d    = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_col_d   = '0;
            out_idx_d   = '0;
            out_last_d  = 1'b0;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < COL; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                idx_q[c]    <= '0;
            end
            ovf_q       <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_col_q   <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            idx_q       <= idx_d;
            ovf_q       <= ovf_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_col_q   <= out_col_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_col   = out_col_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign ovf       = ovf_q;
    assign idle      = (&fifo_empty) && !out_valid_q;

endmodule

// File: tb/tb_pea33_ofm_collector.sv
// tb/tb_pea33_ofm_collector.sv - scoreboard bench for pea33_ofm_collector

module tb_pea33_ofm_collector;

    localparam int COL = 8;
    localparam int W   = 25;

    logic           clk = 1'b0;
    logic           rstn;
    logic           start;
    logic [COL-1:0] sum_valid;
    logic [COL*W-1:0] sum;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [2:0]     out_col;
    logic [3:0]     out_idx;
    logic           out_last;
    logic [COL-1:0] ovf;
    logic           idle;

    pea33_ofm_collector dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .sum_valid (sum_valid),
        .sum       (sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_col   (out_col),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .ovf       (ovf),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int col;
        int idx;
        int last;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push_exp(input int d, input int c, input int ix, input int l);
        exp_t e;
        e.data = d; e.col = c; e.idx = ix; e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic set_sum(input int c, input int v);
        sum[c*W +: W] = W'(v);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((!idle || exp_q.size() != 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, (n < 300) ? 1 : 0, 1);
    endtask

    // Monitor: every accepted output word is compared to the head of the scoreboard
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", longint'(int'($signed(out_data))), e.data);
                check("out_col",  out_col,  e.col);
                check("out_idx",  out_idx,  e.idx);
                check("out_last", out_last, e.last);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; start = 1'b0; sum_valid = '0; sum = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_out_col",   out_col,   0);
        check("rst_out_idx",   out_idx,   0);
        check("rst_out_last",  out_last,  0);
        check("rst_ovf",       ovf,       0);
        check("rst_idle",      idle,      1);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Single column, one full tile line, latency of the first word
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sum_valid = 8'h01;
            set_sum(0, i + 1);
            push_exp(i + 1, 0, i, (i == 15) ? 1 : 0);
            @(posedge clk); #1;
            if (i == 0) check("lat_edge_k",  out_valid, 0);
            if (i == 1) check("lat_edge_k1", out_valid, 1);
        end
        sum_valid = '0;
        wait_drain("drain_single");

        // All columns in one cycle, round-robin from column 0
        do_start();
        sum_valid = 8'hFF;
        for (int c = 0; c < COL; c++) begin
            set_sum(c, 100 + c);
            push_exp(100 + c, c, 0, 0);
        end
        @(posedge clk); #1;
        sum_valid = '0;
        wait_drain("drain_all");
        check("all_idle", idle, 1);

        // Backpressure on column 3
        do_start();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sum_valid = 8'h08;
            set_sum(3, 31 + i);
            push_exp(31 + i, 3, i, 0);
            @(posedge clk); #1;
        end
        sum_valid = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold", (out_valid && out_data == W'(31) && out_col == 3'd3) ? 1 : 0, 1);
        end
        check("bp_ovf", ovf, 0);
        out_ready = 1'b1;
        wait_drain("drain_bp");

        // Overflow on column 2: 1 in output register + 8 in FIFO, 10th dropped
        do_start();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sum_valid = 8'h04;
            set_sum(2, 201 + i);
            if (i < 9) push_exp(201 + i, 2, i, 0);
            @(posedge clk); #1;
        end
        sum_valid = '0;
        @(posedge clk); #1;
        check("ovf_set", ovf, 8'h04);
        out_ready = 1'b1;
        wait_drain("drain_ovf");
        check("ovf_sticky", ovf, 8'h04);
        do_start();
        check("ovf_cleared", ovf, 0);

        // start mid-stream on column 5
        for (int i = 0; i < 3; i++) begin
            sum_valid = 8'h20;
            set_sum(5, 50 + i);
            push_exp(50 + i, 5, i, 0);
            @(posedge clk); #1;
        end
        sum_valid = '0;
        wait_drain("drain_pre_start");
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sum_valid = 8'h20;
            set_sum(5, 60 + i);
            @(posedge clk); #1;
        end
        sum_valid = '0;
        do_start();
        check("start_out_valid", out_valid, 0);
        check("start_idle",      idle,      1);
        out_ready = 1'b1;
        sum_valid = 8'h20;
        set_sum(5, 77);
        push_exp(77, 5, 0, 0);
        @(posedge clk); #1;
        sum_valid = '0;
        wait_drain("drain_post_start");

        // Sign handling on column 1
        sum_valid = 8'h02;
        set_sum(1, -7);
`ifdef PEA33_OFM_RELU_EN
        push_exp(0, 1, 0, 0);
`else
        push_exp(-7, 1, 0, 0);
`endif
        @(posedge clk); #1;
        set_sum(1, 7);
        push_exp(7, 1, 1, 0);
        @(posedge clk); #1;
        sum_valid = '0;
        wait_drain("drain_sign");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
